// File: rtl/cpu_control_unit_pkg.sv
// Shared constants and types for the multi-cycle CPU control unit:
// widths, opcodes, ALU/writeback codes, FSM states and the decoded control bundle.
package cpu_control_unit_pkg;

   localparam int BUS_W   = 16;
   localparam int ADDR_W  = 4;
   localparam int FS_W    = 3;
   localparam int MADDR_W = 8;

   localparam logic [3:0] OP_ADDI = 4'h8;
   localparam logic [3:0] OP_LD   = 4'h9;
   localparam logic [3:0] OP_JAL  = 4'hA;
   localparam logic [3:0] OP_BZ   = 4'hB;
   localparam logic [3:0] OP_BNZ  = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [FS_W-1:0] FS_ADD = 3'b000;

   // {MD, BL} writeback source select
   localparam logic [1:0] WB_F    = 2'b11;
   localparam logic [1:0] WB_PC   = 2'b10;
   localparam logic [1:0] WB_MEM  = 2'b01;
   localparam logic [1:0] WB_ZERO = 2'b00;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXEC    = 3'd2,
      ST_MEMWAIT = 3'd3,
      ST_HALT    = 3'd4
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] da;
      logic [ADDR_W-1:0] aa;
      logic [ADDR_W-1:0] ba;
      logic [FS_W-1:0]   fs;
      logic              mb;
      logic [1:0]        wb;
      logic              wr_exec;
      logic              is_ld;
      logic              is_jal;
      logic              is_bz;
      logic              is_bnz;
      logic              is_halt;
      logic [7:0]        imm8;
   } ctrl_t;

   function automatic logic [BUS_W-1:0] sext8(input logic [7:0] v);
      return {{(BUS_W-8){v[7]}}, v};
   endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// Bus bundle between the control unit and instruction ROM, data memory and datapath.
// master = control unit side, slave = environment side.
interface cpu_control_unit_if;
   import cpu_control_unit_pkg::*;

   logic               instr_req;
   logic [BUS_W-1:0]   instr_addr;
   logic               instr_valid;
   logic [BUS_W-1:0]   instr_data;
   logic               mem_req;
   logic [MADDR_W-1:0] mem_addr;
   logic               mem_valid;
   logic [BUS_W-1:0]   Dout;
   logic [ADDR_W-1:0]  DA;
   logic [ADDR_W-1:0]  AA;
   logic [ADDR_W-1:0]  BA;
   logic [FS_W-1:0]    FS;
   logic               MB;
   logic               MD;
   logic               BL;
   logic               RW;
   logic [BUS_W-1:0]   PC;
   logic               halted;

   modport master (
      output instr_req, instr_addr, mem_req, mem_addr,
      output DA, AA, BA, FS, MB, MD, BL, RW, PC, halted,
      input  instr_valid, instr_data, mem_valid, Dout
   );

   modport slave (
      input  instr_req, instr_addr, mem_req, mem_addr,
      input  DA, AA, BA, FS, MB, MD, BL, RW, PC, halted,
      output instr_valid, instr_data, mem_valid, Dout
   );

endinterface

// File: rtl/cpu_control_unit_decoder.sv
// Combinational instruction decode: IR -> register fields, ALU/operand/writeback
// selects and opcode class flags used by the sequencer.
module cpu_instr_decoder
   import cpu_control_unit_pkg::*;
(
   input  logic [BUS_W-1:0] i_ir,
   output ctrl_t            o_ctrl
);

   logic [3:0] w_op;

   assign w_op = i_ir[15:12];

   always_comb begin
      o_ctrl      = '0;
      o_ctrl.da   = i_ir[11:8];
      o_ctrl.aa   = i_ir[7:4];
      o_ctrl.ba   = i_ir[3:0];
      o_ctrl.imm8 = i_ir[7:0];
      o_ctrl.fs   = FS_ADD;
      o_ctrl.wb   = WB_ZERO;
      if (!w_op[3]) begin
         o_ctrl.fs      = w_op[2:0];
         o_ctrl.mb      = 1'b1;
         o_ctrl.wb      = WB_F;
         o_ctrl.wr_exec = 1'b1;
      end else begin
         case (w_op)
            OP_ADDI: begin
               o_ctrl.wb      = WB_F;
               o_ctrl.wr_exec = 1'b1;
            end
            OP_LD: begin
               o_ctrl.wb    = WB_MEM;
               o_ctrl.is_ld = 1'b1;
            end
            OP_JAL: begin
               o_ctrl.wb      = WB_PC;
               o_ctrl.wr_exec = 1'b1;
               o_ctrl.is_jal  = 1'b1;
            end
            OP_BZ:   o_ctrl.is_bz   = 1'b1;
            OP_BNZ:  o_ctrl.is_bnz  = 1'b1;
            OP_HALT: o_ctrl.is_halt = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle CPU sequencer: fetch/decode/execute FSM, program counter, ROM and
// data-memory handshakes; datapath controls are decoded from the registered state and IR.
module cpu_control_unit
   import cpu_control_unit_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   cpu_control_unit_if.master   bus
);

   // state      | meaning
   // ST_FETCH   | request instruction at PC, latch IR and bump PC on instr_valid
   // ST_DECODE  | present register fields, let Dout/F settle
   // ST_EXEC    | single-cycle write, branch/jump PC update
   // ST_MEMWAIT | LD: hold mem_req/mem_addr, write MemIn on mem_valid
   // ST_HALT    | idle until reset

   state_t           r_state;
   logic [BUS_W-1:0] r_pc;
   logic [BUS_W-1:0] r_ir;
   logic             r_live;
   ctrl_t            w_ctrl;
   logic             w_taken;

   cpu_instr_decoder u_dec (
      .i_ir   (r_ir),
      .o_ctrl (w_ctrl)
   );

   assign w_taken = (w_ctrl.is_bz  && (bus.Dout == '0)) ||
                    (w_ctrl.is_bnz && (bus.Dout != '0));

   // r_live keeps the fetch request low through reset and the partial cycle after release
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_FETCH;
         r_pc    <= '0;
         r_ir    <= '0;
         r_live  <= 1'b0;
      end else begin
         r_live <= 1'b1;
         case (r_state)
            ST_FETCH: begin
               if (r_live && bus.instr_valid) begin
                  r_ir    <= bus.instr_data;
                  r_pc    <= r_pc + 1'b1;
                  r_state <= ST_DECODE;
               end
            end
            ST_DECODE: r_state <= ST_EXEC;
            ST_EXEC: begin
               if (w_ctrl.is_jal)
                  r_pc <= {{(BUS_W-8){1'b0}}, w_ctrl.imm8};
               else if (w_taken)
                  r_pc <= r_pc + sext8(w_ctrl.imm8);
               if (w_ctrl.is_ld)
                  r_state <= ST_MEMWAIT;
               else if (w_ctrl.is_halt)
                  r_state <= ST_HALT;
               else
                  r_state <= ST_FETCH;
            end
            ST_MEMWAIT: begin
               if (bus.mem_valid)
                  r_state <= ST_FETCH;
            end
            ST_HALT: r_state <= ST_HALT;
            default: r_state <= ST_FETCH;
         endcase
      end
   end

   logic               w_instr_req;
   logic               w_mem_req;
   logic [MADDR_W-1:0] w_mem_addr;
   logic [ADDR_W-1:0]  w_da;
   logic [ADDR_W-1:0]  w_aa;
   logic [ADDR_W-1:0]  w_ba;
   logic [FS_W-1:0]    w_fs;
   logic               w_mb;
   logic [1:0]         w_wb;
   logic               w_rw;
   logic               w_halted;

   always_comb begin
      w_instr_req = 1'b0;
      w_mem_req   = 1'b0;
      w_mem_addr  = '0;
      w_da        = '0;
      w_aa        = '0;
      w_ba        = '0;
      w_fs        = '0;
      w_mb        = 1'b0;
      w_wb        = WB_ZERO;
      w_rw        = 1'b0;
      w_halted    = 1'b0;
      case (r_state)
         ST_FETCH: w_instr_req = r_live;
         ST_DECODE, ST_EXEC, ST_MEMWAIT: begin
            w_da = w_ctrl.da;
            w_aa = w_ctrl.aa;
            w_ba = w_ctrl.ba;
            w_fs = w_ctrl.fs;
            w_mb = w_ctrl.mb;
            w_wb = w_ctrl.wb;
            if (r_state == ST_EXEC)
               w_rw = w_ctrl.wr_exec;
            if (r_state == ST_MEMWAIT) begin
               w_mem_req  = 1'b1;
               w_mem_addr = w_ctrl.imm8;
               w_rw       = bus.mem_valid;
            end
         end
         ST_HALT: w_halted = 1'b1;
         default: ;
      endcase
   end

   assign bus.instr_req  = w_instr_req;
   assign bus.instr_addr = r_pc;
   assign bus.mem_req    = w_mem_req;
   assign bus.mem_addr   = w_mem_addr;
   assign bus.DA         = w_da;
   assign bus.AA         = w_aa;
   assign bus.BA         = w_ba;
   assign bus.FS         = w_fs;
   assign bus.MB         = w_mb;
   assign bus.MD         = w_wb[1];
   assign bus.BL         = w_wb[0];
   assign bus.RW         = w_rw;
   assign bus.PC         = r_pc;
   assign bus.halted     = w_halted;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: directed program with an instruction-level reference
// model checked every falling edge, plus literal expectations from the test plan.
module tb_cpu_control_unit;
   import cpu_control_unit_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   cpu_control_unit_if bus();

   cpu_control_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected control fields straight from the opcode table
   function automatic logic [2:0] exp_fs(input logic [3:0] op);
      return (op < 4'h8) ? op[2:0] : 3'b000;
   endfunction
   function automatic logic exp_mb(input logic [3:0] op);
      return op < 4'h8;
   endfunction
   function automatic logic [1:0] exp_wb(input logic [3:0] op);
      if (op <= 4'h8) return 2'b11;
      if (op == 4'h9) return 2'b01;
      if (op == 4'hA) return 2'b10;
      return 2'b00;
   endfunction
   function automatic logic exp_wr(input logic [3:0] op);
      return (op <= 4'h8) || (op == 4'hA);
   endfunction

   // Model: phase 0 = waiting for fetch, 1/2 = cycles after accept, 3 = load wait,
   // 4 = partial cycle right after reset release
   logic [15:0] m_pc = 16'h0;
   logic [15:0] m_ir = 16'h0;
   int          m_ph = 4;
   bit          m_halted = 1'b0;

   task automatic chk_fields(input string tag);
      chk({tag, "_DA"}, bus.DA, m_ir[11:8]);
      chk({tag, "_AA"}, bus.AA, m_ir[7:4]);
      chk({tag, "_BA"}, bus.BA, m_ir[3:0]);
      chk({tag, "_FS"}, bus.FS, exp_fs(m_ir[15:12]));
      chk({tag, "_MB"}, bus.MB, exp_mb(m_ir[15:12]));
      chk({tag, "_MDBL"}, {bus.MD, bus.BL}, exp_wb(m_ir[15:12]));
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         chk("m_rst_req", bus.instr_req, 1'b0);
         chk("m_rst_memreq", bus.mem_req, 1'b0);
         chk("m_rst_rw", bus.RW, 1'b0);
         chk("m_rst_halted", bus.halted, 1'b0);
         chk("m_rst_pc", bus.PC, 16'h0);
         chk("m_rst_ctrl", {bus.DA, bus.AA, bus.BA, bus.FS, bus.MB, bus.MD, bus.BL}, 0);
         m_pc = 16'h0; m_ph = 4; m_halted = 1'b0;
      end else if (m_halted) begin
         chk("m_halt_flag", bus.halted, 1'b1);
         chk("m_halt_req", bus.instr_req, 1'b0);
         chk("m_halt_memreq", bus.mem_req, 1'b0);
         chk("m_halt_rw", bus.RW, 1'b0);
      end else begin
         case (m_ph)
            4: begin
               chk("m_post_rst_req", bus.instr_req, 1'b0);
               chk("m_post_rst_rw", bus.RW, 1'b0);
               m_ph = 0;
            end
            0: begin
               chk("m_fetch_req", bus.instr_req, 1'b1);
               chk("m_fetch_addr", bus.instr_addr, m_pc);
               chk("m_fetch_pc", bus.PC, m_pc);
               chk("m_fetch_rw", bus.RW, 1'b0);
               chk("m_fetch_memreq", bus.mem_req, 1'b0);
               chk("m_fetch_halted", bus.halted, 1'b0);
               if (bus.instr_valid) begin
                  m_ir = bus.instr_data;
                  m_pc = m_pc + 16'd1;
                  m_ph = 1;
               end
            end
            1: begin
               chk("m_dec_req", bus.instr_req, 1'b0);
               chk("m_dec_rw", bus.RW, 1'b0);
               chk_fields("m_dec");
               m_ph = 2;
            end
            2: begin
               chk("m_exec_rw", bus.RW, exp_wr(m_ir[15:12]));
               chk("m_exec_pc", bus.PC, m_pc);
               chk("m_exec_memreq", bus.mem_req, 1'b0);
               chk_fields("m_exec");
               m_ph = 0;
               case (m_ir[15:12])
                  4'h9: m_ph = 3;
                  4'hA: m_pc = {8'h00, m_ir[7:0]};
                  4'hB: if (bus.Dout == 16'h0) m_pc = m_pc + 16'($signed(m_ir[7:0]));
                  4'hC: if (bus.Dout != 16'h0) m_pc = m_pc + 16'($signed(m_ir[7:0]));
                  4'hF: m_halted = 1'b1;
                  default: ;
               endcase
            end
            3: begin
               chk("m_mw_memreq", bus.mem_req, 1'b1);
               chk("m_mw_addr", bus.mem_addr, m_ir[7:0]);
               chk("m_mw_rw", bus.RW, bus.mem_valid);
               chk_fields("m_mw");
               if (bus.mem_valid) m_ph = 0;
            end
            default: m_ph = 0;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench one step into the DECODE cycle
   task automatic do_fetch(input logic [15:0] instr, input int delay);
      int n = 0;
      while (!bus.instr_req && n < 20) begin
         tick();
         n++;
      end
      if (!bus.instr_req) chk("fetch_wait_timeout", bus.instr_req, 1'b1);
      repeat (delay) tick();
      bus.instr_valid = 1'b1;
      bus.instr_data  = instr;
      tick();
      bus.instr_valid = 1'b0;
   endtask

   task automatic step(input logic [15:0] instr, input logic [15:0] dout, input int delay);
      bus.Dout = dout;
      do_fetch(instr, delay);
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.instr_valid = 1'b0;
      bus.instr_data  = 16'h0;
      bus.mem_valid   = 1'b0;
      bus.Dout        = 16'h0;
      #2 reset = 1'b0;
      repeat (3) tick();
      chk("rst_instr_req", bus.instr_req, 1'b0);
      chk("rst_pc", bus.PC, 16'h0);
      chk("rst_halted", bus.halted, 1'b0);
      reset = 1'b1;
      tick();
      chk("first_req", bus.instr_req, 1'b1);
      chk("first_addr", bus.instr_addr, 16'h0000);

      // ALU reg-reg 0x2312 at PC 0
      do_fetch(16'h2312, 0);
      tick();
      chk("alu_DA", bus.DA, 4'd3);
      chk("alu_AA", bus.AA, 4'd1);
      chk("alu_BA", bus.BA, 4'd2);
      chk("alu_FS", bus.FS, 3'b010);
      chk("alu_MB", bus.MB, 1'b1);
      chk("alu_MDBL", {bus.MD, bus.BL}, 2'b11);
      chk("alu_RW", bus.RW, 1'b1);
      chk("alu_PC", bus.PC, 16'h0001);
      tick();
      chk("alu_rw_once", bus.RW, 1'b0);
      chk("alu_next_addr", bus.instr_addr, 16'h0001);

      step(16'h8105, 16'h0, 2);

      // LD 0x9420 at PC 2, mem_valid three cycles late
      do_fetch(16'h9420, 0);
      tick();
      chk("ld_exec_rw", bus.RW, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("ld_wait_memreq", bus.mem_req, 1'b1);
         chk("ld_wait_addr", bus.mem_addr, 8'h20);
         chk("ld_wait_rw", bus.RW, 1'b0);
         tick();
      end
      bus.mem_valid = 1'b1;
      #1;
      chk("ld_rw", bus.RW, 1'b1);
      chk("ld_MDBL", {bus.MD, bus.BL}, 2'b01);
      chk("ld_DA", bus.DA, 4'd4);
      tick();
      bus.mem_valid = 1'b0;
      #1;
      chk("ld_done_rw", bus.RW, 1'b0);
      chk("ld_done_memreq", bus.mem_req, 1'b0);

      step(16'h7abc, 16'h0, 1);
      step(16'hD000, 16'h0, 0);
      step(16'hE123, 16'h0, 0);
      step(16'hC203, 16'h0, 0);
      chk("bnz_nt_addr", bus.instr_addr, 16'h0007);

      // JAL 0xA640 at PC 7
      do_fetch(16'hA640, 0);
      tick();
      chk("jal_RW", bus.RW, 1'b1);
      chk("jal_MDBL", {bus.MD, bus.BL}, 2'b10);
      chk("jal_DA", bus.DA, 4'd6);
      chk("jal_PC", bus.PC, 16'h0008);
      tick();
      chk("jal_target", bus.instr_addr, 16'h0040);

      step(16'hB0CF, 16'h0, 0);
      chk("bz_back_addr", bus.instr_addr, 16'h0010);
      step(16'hB5FE, 16'h0, 0);
      chk("bz_taken_addr", bus.instr_addr, 16'h000F);
      step(16'hA010, 16'h0, 0);
      step(16'hB5FE, 16'h0005, 0);
      chk("bz_not_taken_addr", bus.instr_addr, 16'h0011);
      step(16'hC1FF, 16'h0003, 0);
      chk("bnz_taken_addr", bus.instr_addr, 16'h0011);

      // HALT, stray valid must be ignored
      step(16'hF000, 16'h0, 0);
      bus.instr_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         chk("halt_flag", bus.halted, 1'b1);
         chk("halt_req", bus.instr_req, 1'b0);
         tick();
      end
      bus.instr_valid = 1'b0;
      reset = 1'b0;
      #1;
      chk("halt_rst_clear", bus.halted, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk("halt_rst_halted", bus.halted, 1'b0);
      chk("halt_rst_req", bus.instr_req, 1'b1);
      chk("halt_rst_addr", bus.instr_addr, 16'h0000);

      // Reset while waiting for load data
      bus.Dout = 16'h0;
      do_fetch(16'h9420, 0);
      tick();
      tick();
      chk("abort_memreq_before", bus.mem_req, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("abort_memreq", bus.mem_req, 1'b0);
      chk("abort_rw", bus.RW, 1'b0);
      chk("abort_DA", bus.DA, 4'd0);
      chk("abort_MDBL", {bus.MD, bus.BL}, 2'b00);
      chk("abort_pc", bus.PC, 16'h0000);
      chk("abort_req", bus.instr_req, 1'b0);
      bus.mem_valid = 1'b1;
      tick();
      tick();
      bus.mem_valid = 1'b0;
      reset = 1'b1;
      tick();
      chk("abort_refetch_req", bus.instr_req, 1'b1);
      chk("abort_refetch_addr", bus.instr_addr, 16'h0000);

      // PC wrap 0xFFFF -> 0x0000
      step(16'hB0FE, 16'h0, 0);
      chk("wrap_pre_addr", bus.instr_addr, 16'hFFFF);
      step(16'hD000, 16'h0, 0);
      chk("wrap_addr", bus.instr_addr, 16'h0000);
      chk("wrap_pc", bus.PC, 16'h0000);

      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Multi-cycle control unit/sequencer that drives the CPU datapath's control inputs (DA, AA, BA, FS, MB, MD, BL, RW, PC) and consumes its Dout for branch decisions.
- Fetches 16-bit instructions from instruction ROM through a req/valid handshake, decodes them, sequences register writeback and data-memory loads, and maintains the program counter.
- Sits between instruction ROM, data memory and the datapath.

Parameters:
- BUS_W, 16, datapath/PC/instruction width
- ADDR_W, 4, register address width
- FS_W, 3, ALU function select width
- MADDR_W, 8, data-memory address width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- instr_req  out  1  instruction fetch request
- instr_addr  out  BUS_W  fetch address (= PC)
- instr_valid  in  1  instr_data valid this cycle
- instr_data  in  BUS_W  fetched instruction
- mem_req  out  1  data-memory read request
- mem_addr  out  MADDR_W  data-memory read address
- mem_valid  in  1  read data (datapath MemIn) valid this cycle
- Dout  in  BUS_W  datapath value of register DA
- DA, AA, BA  out  ADDR_W each  register addresses (BA doubles as zero-extended immediate when MB=0)
- FS  out  FS_W  ALU function
- MB  out  1  1 = register B operand, 0 = immediate
- MD, BL  out  1 each  writeback select: 11 = F, 10 = PC, 01 = MemIn, 00 = zero
- RW  out  1  register write enable
- PC  out  BUS_W  program counter to datapath
- halted  out  1  HALT executed

Behaviour:
- Instruction format: op = IR[15:12], DA = IR[11:8], AA = IR[7:4], BA = IR[3:0]; imm8 = IR[7:0].
- Opcodes:
  - 0x0–0x7 ALU reg-reg: FS = op[2:0], MB = 1, MD/BL = 11, write DA.
  - 0x8 ADDI: FS = 000, MB = 0, MD/BL = 11, write DA.
  - 0x9 LD: mem_addr = imm8, MD/BL = 01, write DA.
  - 0xA JAL: MD/BL = 10 (writes incremented PC to DA), then PC <= zero-extended imm8.
  - 0xB BZ: if Dout == 0, PC <= PC + sign-extended imm8.
  - 0xC BNZ: same as BZ on Dout != 0.
  - 0xF HALT.
  - 0xD, 0xE: NOP.
- States: FETCH, DECODE, EXEC, MEMWAIT, HALT.
- FETCH: instr_req = 1 while waiting. On instr_valid, latch IR and set PC <= PC + 1 (16-bit wrap, 0xFFFF -> 0x0000); next state DECODE.
- DECODE: drive DA/AA/BA/FS/MB from IR, RW = 0; one cycle for Dout/F to settle; next state EXEC.
- EXEC:
  - ALU/ADDI/JAL: RW = 1 for exactly one cycle; JAL also loads PC at the same edge.
  - BZ/BNZ: evaluate Dout, update PC (modulo 2^16), RW = 0.
  - NOP: no write.
  - Next state FETCH, except LD -> MEMWAIT and HALT -> HALT.
- MEMWAIT: mem_req = 1 and mem_addr held until mem_valid. RW = 1 combinationally in the mem_valid cycle only; next state FETCH.
- HALT: halted = 1, all requests 0, RW = 0; sticky until reset.
- Control outputs are pure functions of the registered state and IR. RW is never 1 outside EXEC/MEMWAIT.
- Latency: ALU instruction = fetch wait + 3 cycles (FETCH with instant valid, DECODE, EXEC).
- instr_valid is ignored outside FETCH. mem_valid is ignored outside MEMWAIT.
- Reset (async, reset = 0): state FETCH, PC = 0, IR = 0, all control outputs 0, instr_req/mem_req/halted 0, RW 0.
- Reset mid-operation aborts the instruction with no register write. The first fetch request is issued in the first cycle after deassertion.

Decomposition:
- Shared package: opcode constants, state encoding, FS codes (FS_ADD = 000), MD/BL writeback select constants (WB_F, WB_PC, WB_MEM, WB_ZERO).
- One sub-module: cpu_instr_decoder, a combinational IR -> control-field decode. The FSM, PC and handshakes stay in the top.

Test Plan:
- Reset, then instr_valid immediate with 0x2312 at PC 0 -> instr_addr = 0; 2 cycles later DA = 3, AA = 1, BA = 2, FS = 010, MB = 1, MD/BL = 11, RW = 1 for one cycle; PC = 1.
- LD 0x9420 with mem_valid delayed 3 cycles -> mem_req = 1, mem_addr = 0x20 held for 3 cycles; RW = 1 only in the mem_valid cycle with MD/BL = 01, DA = 4.
- BZ 0xB5FE at PC 0x0010 with Dout = 0 -> next instr_addr = 0x000F. Same with Dout = 5 -> 0x0011.
- JAL 0xA640 at PC 7 -> RW = 1, MD/BL = 10, PC output = 8 during write; next fetch at 0x0040.
- HALT 0xF000 -> halted = 1, instr_req stays 0 for 20 cycles; reset low then high -> halted = 0 and fetch at PC 0.
- Reset asserted during MEMWAIT -> RW never asserted; all outputs 0 immediately; PC = 0.
